// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC interval path: FSM state encoding, flag bit
// positions and the signed interval width derived from the coarse/fine widths.
package tdc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    CALC  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int FLAG_TIMEOUT = 0;
  localparam int FLAG_BADBIN  = 1;
  localparam int FLAGS_W      = 2;

  // One extra bit so start_bin - stop_bin can go negative at zero coarse difference.
  function automatic int interval_width(input int bits_coarse, input int bits_deco);
    return bits_coarse + bits_deco + 1;
  endfunction

  localparam int INTERVAL_W = interval_width(16, 8);

endpackage

// File: rtl/coarse_counter.sv
// Free-running coarse time base, wraps modulo 2^BITS_COARSE.
// Latency: count visible the cycle after reset release; no backpressure.
module coarse_counter #(
  parameter int BITS_COARSE = 16
) (
  input  logic                   wClk,
  input  logic                   wRst,
  output logic [BITS_COARSE-1:0] wCount
);

  always_ff @(posedge wClk or posedge wRst) begin
    if (wRst) wCount <= '0;
    else      wCount <= wCount + BITS_COARSE'(1);
  end

endmodule

// File: rtl/interval_calc.sv
// Start/stop interval: coarse difference * BINS_PER_CLK + start_bin - stop_bin; valid 2 cycles after stop,
// held until wReady (hits meanwhile dropped). INTERVAL_CALC_DROP_CNT_EN adds the wDropCnt dropped-hit counter.
module interval_calc
  import tdc_pkg::*;
#(
  parameter int BITS_DECO    = 8,
  parameter int BITS_COARSE  = 16,
  parameter int BINS_PER_CLK = 100,
  parameter int MAX_CYCLES   = 1000
) (
  input  logic                           wClk,
  input  logic                           wRst,
  input  logic                           wStartHit,
  input  logic [BITS_DECO-1:0]           wStartBin,
  input  logic                           wStopHit,
  input  logic [BITS_DECO-1:0]           wStopBin,
  output logic                           wValid,
  input  logic                           wReady,
  output logic [BITS_COARSE+BITS_DECO:0] wInterval,
  output logic [1:0]                     wFlags
`ifdef INTERVAL_CALC_DROP_CNT_EN
  ,
  output logic [15:0]                    wDropCnt
`endif
);

  localparam int IW = interval_width(BITS_COARSE, BITS_DECO);
  localparam int TW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  logic [1:0]             rst_sync;
  logic                   rst_i;
  logic [BITS_COARSE-1:0] coarse;
  logic [BITS_COARSE-1:0] start_c;
  logic [BITS_COARSE-1:0] stop_c;
  logic [BITS_COARSE-1:0] diff;
  logic [BITS_DECO-1:0]   start_bin;
  logic [BITS_DECO-1:0]   stop_bin;
  logic [TW-1:0]          timer;
  logic                   timeout;
  logic [IW-1:0]          calc;
  state_t                 state;

  // Assert immediately, release two clean edges later.
  always_ff @(posedge wClk or posedge wRst) begin
    if (wRst) rst_sync <= 2'b11;
    else      rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst_i = rst_sync[1];

  coarse_counter #(
    .BITS_COARSE(BITS_COARSE)
  ) u_cnt (
    .wClk  (wClk),
    .wRst  (rst_i),
    .wCount(coarse)
  );

  // Unsigned subtraction in the counter width gives the wrapped difference for free.
  always_comb begin
    diff = stop_c - start_c;
    calc = IW'(diff) * IW'(BINS_PER_CLK) + IW'(start_bin) - IW'(stop_bin);
  end

  always_ff @(posedge wClk or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      start_c   <= '0;
      stop_c    <= '0;
      start_bin <= '0;
      stop_bin  <= '0;
      timer     <= '0;
      timeout   <= 1'b0;
      wValid    <= 1'b0;
      wInterval <= '0;
      wFlags    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wStartHit) begin
            start_c   <= coarse;
            start_bin <= wStartBin;
            timer     <= '0;
            timeout   <= 1'b0;
            if (wStopHit) begin
              stop_c   <= coarse;
              stop_bin <= wStopBin;
              state    <= CALC;
            end else begin
              state <= ARMED;
            end
          end
        end
        ARMED: begin
          if (wStopHit) begin
            stop_c   <= coarse;
            stop_bin <= wStopBin;
            state    <= CALC;
          end else if (timer == TW'(MAX_CYCLES - 1)) begin
            timeout <= 1'b1;
            state   <= CALC;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        CALC: begin
          wInterval            <= timeout ? '0 : calc;
          wFlags[FLAG_TIMEOUT] <= timeout;
          // On timeout no stop bin was latched, so only the start bin can be bad.
          wFlags[FLAG_BADBIN]  <= (start_bin == '0) || (!timeout && (stop_bin == '0));
          wValid               <= 1'b1;
          state                <= HOLD;
        end
        HOLD: begin
          if (wReady) begin
            wValid <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef INTERVAL_CALC_DROP_CNT_EN
  logic        start_drop;
  logic        stop_drop;
  logic [1:0]  ndrop;
  logic [15:0] drop_cnt;

  // A lone stop in IDLE is ignored, not dropped, so it is not counted.
  always_comb begin
    start_drop = wStartHit && (state != IDLE);
    stop_drop  = wStopHit && ((state == CALC) || (state == HOLD));
    ndrop      = {1'b0, start_drop} + {1'b0, stop_drop};
  end

  always_ff @(posedge wClk or posedge rst_i) begin
    if (rst_i)                                 drop_cnt <= '0;
    else if (drop_cnt > 16'hFFFF - 16'(ndrop)) drop_cnt <= 16'hFFFF;
    else                                       drop_cnt <= drop_cnt + 16'(ndrop);
  end

  assign wDropCnt = drop_cnt;
`endif

endmodule
